instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the host (initiator) end of the AvalonMmRead interface whose agent end is the instruction ROM. Issues pipelined sequential word reads from a program counter, buffers returned words with their addresses in a small FIFO, and hands them to the decode stage over a valid/ready handshake. Supports redirect (branch/jump) with flush, discarding responses to requests already in flight.

## Interface
- DEPTH, 4, FIFO entries and maximum outstanding reads; power of two, ≥2; ≥4 required for one word/cycle with a 1-cycle-latency agent
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- mem_host  AvalonMmRead.Host  -  address(32), read, waitrequest, readdatavalid, agent_to_host(32)
- redirect  in  1  restart fetch at redirect_pc, flush buffered/in-flight words
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- instr_valid  out  1  FIFO head valid
- instr  out  32  instruction word at FIFO head
- instr_pc  out  32  address of instr
- instr_ready  in  1  consumer pops head when instr_valid && instr_ready

## Operation
- Registers: fetch_pc (next request address), resp_pc (address of next live response), live (in-flight reads to keep), discard (in-flight reads to drop), FSM state, FIFO.
- Reset values: read=0, address=RESET_PC, fetch_pc=resp_pc=RESET_PC, live=discard=0, FIFO empty, instr_valid=0, state FETCH_IDLE.
- FSM, read/address registered:
  - FETCH_IDLE: read=0. Go to FETCH_REQ, address=fetch_pc, when credit available.
  - FETCH_REQ: read=1; address held stable while waitrequest=1. Accept on !waitrequest: fetch_pc=address+4; live++ (or discard++ if stale); if credit remains, stay in FETCH_REQ with address+4, else FETCH_IDLE.
- Credit: fifo_count + live + discard + (request pending ? 1 : 0) < DEPTH, using next-cycle counts. FIFO can never overflow; readdatavalid is never backpressured.
- Response on readdatavalid: if discard>0, drop and discard--. Else push {agent_to_host, resp_pc}, resp_pc+=4, live--.
- Redirect (one cycle):
  - FIFO flushed; pop ignored.
  - discard += live; live=0.
  - fetch_pc=resp_pc={redirect_pc[31:2],2'b00}.
  - A readdatavalid in the same cycle is dropped.
  - A request pending with waitrequest=1 stays asserted with unchanged address (Avalon hold rule) but is marked stale; on acceptance it counts into discard. A request accepted in the redirect cycle also counts into discard.
  - The first new request issues the cycle after redirect, or after the stale one is accepted.
- Push and pop in the same cycle are allowed at any occupancy.

## Timing
- Reset release → read=1 at address RESET_PC on the first clk edge.
- With a 1-cycle agent (waitrequest=0): read accepted in cycle N, readdatavalid in N+1, instr_valid in N+2.
- Sustained rate with DEPTH=4 and instr_ready=1: one word/cycle, address incrementing by 4 each cycle.
- instr_ready=0: issue stops once credit is exhausted; at most DEPTH reads outstanding or buffered.
- Redirect in cycle R: instr_valid=0 in R+1. For a 1-cycle agent with no stale request, the first new word is valid in R+3.
- Async reset mid-operation clears everything immediately; the agent shares rst, so no stray responses arrive.

## Structure
- Types package: reuse word; add enum fetch_state_t {FETCH_IDLE, FETCH_REQ}.
- Sub-module fetch_fifo: synchronous FIFO, DEPTH entries of {word data, word pc}, with push, pop, flush, count, combinational head output.
- instr_fetch contains the FSM, counters and redirect logic.

## Test plan
- Reset, 1-cycle agent, instr_ready=1: words from 0x0,0x4,0x8,… appear on consecutive cycles; instr_pc matches; first instr_valid 2 cycles after first read.
- instr_ready=0 for 10 cycles: exactly 4 reads issued, FIFO full, read=0. Release: 4 words drain in order, then fetch resumes at 0x10.
- Agent holds waitrequest=1 for 3 cycles: address and read stable throughout; no duplicate or skipped address.
- Redirect to 0x100 with 2 reads in flight: both responses dropped; next delivered word has instr_pc=0x100.
- Redirect while waitrequest=1 on request 0x20: 0x20 still completes and is discarded; fetch restarts at redirect_pc.
- Redirect to 0x203: fetch issued at 0x200; assert rst mid-stream: read=0, instr_valid=0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: machine word, fetch FSM states,
// and the buffered {instruction, address} entry.
package instr_fetch_pkg;

  typedef logic [31:0] word;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    word data;
    word pc;
  } fetch_entry_t;

  function automatic word word_align(input word a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO of {instruction word, fetch address} with flush; head is
// combinational, push and pop may coincide at any occupancy.
module instr_fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic [31:0]                push_pc,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                head_data,
  output logic [31:0]                head_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  fetch_entry_t mem_q [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic push_en, pop_en, wr_en;

  always_comb begin
    pop_en   = pop && (count_q != '0);
    push_en  = push && ((count_q != cnt_t'(DEPTH)) || pop_en);
    wr_en    = push_en && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push_en) - cnt_t'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{data: push_data, pc: push_pc};
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q].data;
  assign head_pc   = mem_q[rd_ptr_q].pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: pipelined sequential Avalon-MM reads from the PC into a
// credit-limited FIFO, with redirect that flushes and drops in-flight responses.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [31:0] mem_agent_to_host,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 2;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [SW-1:0] sum_t;

  fetch_state_t state_q, state_d;
  word  addr_q, addr_d, fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target_pc;
  cnt_t live_q, live_d, discard_q, discard_d;
  cnt_t fifo_count, count_d, live_rsp, disc_rsp;
  logic stale_q, stale_d;
  logic accept, hold, rsp_live, rsp_drop, push, pop, credit;

  assign instr_valid = (fifo_count != '0);
  assign mem_read    = (state_q == FETCH_REQ);
  assign mem_address = addr_q;
  assign pop         = instr_valid && instr_ready && !redirect;

  always_comb begin
    target_pc = word_align(redirect_pc);
    accept    = (state_q == FETCH_REQ) && !mem_waitrequest;
    hold      = (state_q == FETCH_REQ) && mem_waitrequest;
    rsp_drop  = mem_readdatavalid && (discard_q != '0);
    rsp_live  = mem_readdatavalid && (discard_q == '0);
    push      = rsp_live && !redirect;
    live_rsp  = live_q - cnt_t'(rsp_live);
    disc_rsp  = discard_q - cnt_t'(rsp_drop);

    // Anything accepted before or during a redirect, or accepted while stale, is dropped.
    if (redirect) begin
      live_d    = '0;
      discard_d = disc_rsp + live_rsp + cnt_t'(accept);
      count_d   = '0;
    end else begin
      live_d    = live_rsp + cnt_t'(accept && !stale_q);
      discard_d = disc_rsp + cnt_t'(accept && stale_q);
      count_d   = fifo_count + cnt_t'(push) - cnt_t'(pop);
    end
    stale_d = hold && (stale_q || redirect);

    fetch_pc_d = fetch_pc_q;
    if (redirect)                fetch_pc_d = target_pc;
    else if (accept && !stale_q) fetch_pc_d = addr_q + 32'd4;

    resp_pc_d = resp_pc_q;
    if (redirect)  resp_pc_d = target_pc;
    else if (push) resp_pc_d = resp_pc_q + 32'd4;

    credit = (sum_t'(count_d) + sum_t'(live_d) + sum_t'(discard_d)) < sum_t'(DEPTH);

    // A request stalled by waitrequest keeps its address until accepted.
    state_d = state_q;
    addr_d  = addr_q;
    if (!hold) begin
      if (credit) begin
        state_d = FETCH_REQ;
        addr_d  = fetch_pc_d;
      end else begin
        state_d = FETCH_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH_IDLE;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      discard_q  <= '0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
      stale_q    <= stale_d;
    end
  end

  instr_fetch_fifo #(.DEPTH(DEPTH)) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem_agent_to_host),
    .push_pc   (resp_pc_q),
    .pop       (pop),
    .flush     (redirect),
    .count     (fifo_count),
    .head_data (instr),
    .head_pc   (instr_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: 1-cycle Avalon agent model, cycle table, scoreboard
// of accepted reads, and hand sequences for waitrequest, redirect and reset.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic        mem_readdatavalid;
  logic [31:0] mem_agent_to_host;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t        sb_q[$];
  logic [31:0] exp_acc = RESET_PC;
  logic        stale_pend = 1'b0;
  logic [31:0] stale_addr = 32'h0;

  typedef struct {
    logic        rdy;
    logic        wt;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[20];

  instr_fetch #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_agent_to_host (mem_agent_to_host),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .instr_ready       (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] agent_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // ROM agent: every accepted read returns one cycle later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_readdatavalid <= 1'b0;
      mem_agent_to_host <= 32'h0;
    end else begin
      mem_readdatavalid <= mem_read && !mem_waitrequest;
      mem_agent_to_host <= agent_word(mem_address);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs at every negedge: tracks accepted reads and checks delivered words.
  task automatic monitor();
    exp_t e;
    if (!rst) begin
      sb_q.delete();
      exp_acc    = RESET_PC;
      stale_pend = 1'b0;
      return;
    end
    if (instr_valid && instr_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got word at pc %h, expected none", instr_pc);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", instr_pc, e.pc);
        check("sb_data", instr, e.data);
      end
    end
    if (mem_read && !mem_waitrequest) begin
      if (stale_pend) begin
        check("stale_addr", mem_address, stale_addr);
        stale_pend = 1'b0;
      end else begin
        check("seq_addr", mem_address, exp_acc);
        if (!redirect) sb_q.push_back('{mem_address, agent_word(mem_address)});
        exp_acc = exp_acc + 32'd4;
      end
    end else if (mem_read && redirect) begin
      stale_pend = 1'b1;
      stale_addr = mem_address;
    end
    if (redirect) begin
      sb_q.delete();
      exp_acc = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      sample();
    end
  endtask

  initial begin
    logic [31:0] held;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
    for (int i = 6; i < 14; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 32'h14, 1'b1, 32'h08};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h08};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 32'h28, 1'b1, 32'h1C};

    repeat (3) @(posedge clk);
    #1;
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", mem_address, RESET_PC);
    rst = 1'b1;
    sample();

    // Startup latency, sustained rate, backpressure to full, then drain.
    for (int i = 0; i < 20; i++) begin
      step();
      instr_ready     = vecs[i].rdy;
      mem_waitrequest = vecs[i].wt;
      sample();
      check($sformatf("vec%0d_read", i), 32'(mem_read), 32'(vecs[i].exp_read));
      check($sformatf("vec%0d_addr", i), mem_address, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
    end

    // Waitrequest held for 3 cycles: request stays put, then advances by one word.
    step();
    mem_waitrequest = 1'b1;
    sample();
    held = mem_address;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) mem_waitrequest = 1'b0;
      sample();
      check("wait_read", 32'(mem_read), 32'd1);
      check("wait_addr", mem_address, held);
    end
    step();
    sample();
    check("wait_next_addr", mem_address, held + 32'd4);
    run(3);

    // Redirect with reads in flight: old responses dropped, new word in R+3.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    sample();
    step();
    redirect = 1'b0;
    sample();
    check("redir_valid_r1", 32'(instr_valid), 32'd0);
    check("redir_read_r1", 32'(mem_read), 32'd1);
    check("redir_addr_r1", mem_address, 32'h100);
    step();
    sample();
    check("redir_valid_r2", 32'(instr_valid), 32'd0);
    step();
    sample();
    check("redir_valid_r3", 32'(instr_valid), 32'd1);
    check("redir_pc_r3", instr_pc, 32'h100);
    check("redir_data_r3", instr, agent_word(32'h100));
    run(4);

    // Redirect while a request is stalled: it completes, is dropped, then 0x300.
    step();
    mem_waitrequest = 1'b1;
    sample();
    held = mem_address;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    sample();
    check("stale_hold_addr0", mem_address, held);
    step();
    redirect = 1'b0;
    sample();
    check("stale_hold_addr1", mem_address, held);
    check("stale_hold_read", 32'(mem_read), 32'd1);
    check("stale_valid", 32'(instr_valid), 32'd0);
    step();
    mem_waitrequest = 1'b0;
    sample();
    check("stale_hold_addr2", mem_address, held);
    step();
    sample();
    check("stale_new_read", 32'(mem_read), 32'd1);
    check("stale_new_addr", mem_address, 32'h300);
    run(2);
    check("stale_first_valid", 32'(instr_valid), 32'd1);
    check("stale_first_pc", instr_pc, 32'h300);
    run(3);

    // Misaligned redirect target, then asynchronous reset mid-stream.
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    sample();
    step();
    redirect = 1'b0;
    sample();
    check("align_addr", mem_address, 32'h200);
    run(4);
    step();
    rst = 1'b0;
    #1;
    check("arst_read", 32'(mem_read), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_addr", mem_address, RESET_PC);
    sample();
    run(1);
    step();
    rst = 1'b1;
    sample();
    step();
    sample();
    check("restart_read", 32'(mem_read), 32'd1);
    check("restart_addr", mem_address, RESET_PC);
    run(2);
    check("restart_valid", 32'(instr_valid), 32'd1);
    check("restart_pc", instr_pc, RESET_PC);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
